approx_mult_seq_nxn: RTL



---
 rtl/approx_mult_seq_nxn.sv | 135 +++++++++++++
 1 files changed

// File: rtl/approx_mult_seq_nxn.sv
// Iterative W x W approximate multiplier: one 4x4 digit product per clock, with exact, approx-add and approx-OR modes.
// Optional APPROX_MULT_ZERO_SKIP_EN: a zero operand finishes one cycle after acceptance with R=0.
module approx_mult_seq_nxn #(
  parameter int W          = 16,
  parameter int APPROX_LVL = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] R
);

  localparam int K  = W / 4;
  localparam int DW = (K > 1) ? $clog2(K) : 1;
  localparam logic [DW-1:0] DMAX = DW'(K - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [1:0]       m_reg;
  logic [2*W-1:0]   acc;
  logic [DW-1:0]    di;
  logic [DW-1:0]    dj;
`ifdef APPROX_MULT_ZERO_SKIP_EN
  logic             zs;
`endif

  function automatic logic [7:0] mul_exact(input logic [3:0] a, input logic [3:0] b);
    return 8'(a) * 8'(b);
  endfunction

  // Approximate digit product ignores both operand LSBs.
  function automatic logic [7:0] mul_approx(input logic [3:0] a, input logic [3:0] b);
    return 8'(a & 4'hE) * 8'(b & 4'hE);
  endfunction

  logic [3:0]     a_dig;
  logic [3:0]     b_dig;
  logic [31:0]    dsum;
  logic           in_region;
  logic           use_approx;
  logic           use_or;
  logic [7:0]     p;
  logic [2*W-1:0] term;
  logic [2*W-1:0] acc_next;
  logic           last_step;

  always_comb begin
    a_dig      = a_reg[4*di +: 4];
    b_dig      = b_reg[4*dj +: 4];
    dsum       = 32'(di) + 32'(dj);
    in_region  = dsum < 32'(APPROX_LVL);
    use_approx = in_region && (m_reg == 2'b01 || m_reg == 2'b10);
    use_or     = in_region && (m_reg == 2'b10);
    p          = use_approx ? mul_approx(a_dig, b_dig) : mul_exact(a_dig, b_dig);
    term       = (2*W)'(p) << (dsum * 32'd4);
    acc_next   = use_or ? (acc | term) : (acc + term);
    last_step  = (di == DMAX) && (dj == DMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      R         <= '0;
      acc       <= '0;
      di        <= '0;
      dj        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      m_reg     <= 2'b00;
`ifdef APPROX_MULT_ZERO_SKIP_EN
      zs        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            m_reg    <= mode;
            acc      <= '0;
            di       <= '0;
            dj       <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
`ifdef APPROX_MULT_ZERO_SKIP_EN
            zs       <= (A == '0) || (B == '0);
`endif
          end
        end
        CALC: begin
`ifdef APPROX_MULT_ZERO_SKIP_EN
          if (zs) begin
            R         <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else
`endif
          begin
            acc <= acc_next;
            if (last_step) begin
              R         <= acc_next;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (di == DMAX) begin
              di <= '0;
              dj <= dj + 1'b1;
            end else begin
              di <= di + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
